// File: rtl/mac_sequencer.sv
// Programmable multiply-accumulate sequencer running a host-loaded program over an external sample RAM.
// Latency: 3 cycles per instruction (FETCH/ISSUE/EXEC); a SAVE result strobes one cycle after its EXEC.
// Backpressure: none on results; the host bus acks once per request, and frame_start while busy is dropped.
module mac_sequencer #(
    parameter int CHANNELS   = 8,
    parameter int SAMPLE_W   = 16,
    parameter int GAIN_W     = 16,
    parameter int ACC_W      = 40,
    parameter int PROG_DEPTH = 64,
    localparam int CHAN_W    = $clog2(CHANNELS),
    localparam int PC_W      = $clog2(PROG_DEPTH)
) (
    input  logic                       ck,
    input  logic                       rst,
    input  logic                       iomem_valid,
    input  logic [3:0]                 iomem_wstrb,
    input  logic [31:0]                iomem_addr,
    input  logic [31:0]                iomem_wdata,
    output logic                       iomem_ready,
    output logic [31:0]                iomem_rdata,
    input  logic                       frame_start,
    output logic [CHAN_W+4:0]          sample_addr,
    input  logic signed [SAMPLE_W-1:0] sample_data,
    output logic                       out_valid,
    output logic [CHAN_W-1:0]          out_chan,
    output logic signed [SAMPLE_W-1:0] out_data,
    output logic                       busy
);
    localparam int PROD_W = SAMPLE_W + GAIN_W;

    localparam logic [6:0] OP_NOOP = 7'b0000000;
    localparam logic [6:0] OP_MAC  = 7'b1000000;
    localparam logic [6:0] OP_MACZ = 7'b1000010;
    localparam logic [6:0] OP_MSU  = 7'b1000001;
    localparam logic [6:0] OP_SAVE = 7'b1010000;
    localparam logic [6:0] OP_HALT = 7'b1111111;

    typedef enum logic [1:0] {IDLE, FETCH, ISSUE, EXEC} state_t;

    state_t                    state_q, state_d;
    logic [31:0]               prog [PROG_DEPTH];
    logic [31:0]               ir;
    logic [PC_W-1:0]           pc;
    logic signed [ACC_W-1:0]   acc;
    logic                      enable, overrun, bad_op, wr_conflict;
    logic                      bus_armed;

    logic [6:0]                opcode;
    logic                      run_end;
    logic signed [PROD_W-1:0]  prod;
    logic signed [ACC_W-1:0]   prod_ext;
    logic signed [ACC_W-1:0]   shifted;
    logic [ACC_W-SAMPLE_W:0]   shifted_top;
    logic [SAMPLE_W-1:0]       sat_val;
    logic                      hit_prog, hit_ctrl, bus_take, full_wr, prog_we;
    logic [PC_W-1:0]           widx;
    logic [31:0]               status_word;
    logic                      unused_ok;

    assign busy        = (state_q != IDLE);
    assign opcode      = ir[31:25];
    assign run_end     = (opcode == OP_HALT) || (pc == PC_W'(PROG_DEPTH - 1));
    assign sample_addr = {ir[16 +: CHAN_W], ir[24:20]};

    assign prod     = PROD_W'($signed(sample_data)) * PROD_W'($signed(ir[GAIN_W-1:0]));
    assign prod_ext = ACC_W'(prod);
    assign shifted  = acc >>> ir[5:0];

    // Value fits the output width when every bit above the output sign bit matches it.
    assign shifted_top = shifted[ACC_W-1:SAMPLE_W-1];
    always_comb begin
        sat_val = shifted[SAMPLE_W-1:0];
        if (!((&shifted_top) || !(|shifted_top)))
            sat_val = shifted[ACC_W-1] ? {1'b1, {(SAMPLE_W-1){1'b0}}}
                                       : {1'b0, {(SAMPLE_W-1){1'b1}}};
    end

    assign hit_prog    = (iomem_addr[31:24] == 8'h60);
    assign hit_ctrl    = (iomem_addr[31:24] == 8'h62);
    assign bus_take    = iomem_valid && bus_armed && (hit_prog || hit_ctrl);
    assign full_wr     = (iomem_wstrb == 4'hF);
    assign widx        = iomem_addr[PC_W+1:2];
    assign prog_we     = bus_take && full_wr && hit_prog && !busy;
    assign status_word = {16'h0, 8'(pc), 3'b000, enable, wr_conflict, bad_op, overrun, busy};
    assign unused_ok   = ^{iomem_addr, ir};

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (frame_start && enable) state_d = FETCH;
            FETCH:   state_d = ISSUE;
            ISSUE:   state_d = EXEC;
            EXEC:    state_d = run_end ? IDLE : FETCH;
            default: state_d = IDLE;
        endcase
    end

    // Program RAM survives reset so a host only has to reload it after power-up.
    always_ff @(posedge ck) begin
        if (!rst && prog_we)
            prog[widx] <= iomem_wdata;
    end

    always_ff @(posedge ck) begin
        if (rst) begin
            state_q     <= IDLE;
            pc          <= '0;
            acc         <= '0;
            ir          <= '0;
            out_valid   <= 1'b0;
            out_chan    <= '0;
            out_data    <= '0;
            iomem_ready <= 1'b0;
            iomem_rdata <= '0;
            bus_armed   <= 1'b1;
            enable      <= 1'b0;
            overrun     <= 1'b0;
            bad_op      <= 1'b0;
            wr_conflict <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid   <= 1'b0;
            iomem_ready <= 1'b0;
            if (!iomem_valid)
                bus_armed <= 1'b1;

            if (bus_take) begin
                iomem_ready <= 1'b1;
                bus_armed   <= 1'b0;
                iomem_rdata <= hit_prog ? prog[widx] : status_word;
                if (full_wr && hit_ctrl) begin
                    enable <= iomem_wdata[0];
                    if (iomem_wdata[1]) begin
                        overrun     <= 1'b0;
                        bad_op      <= 1'b0;
                        wr_conflict <= 1'b0;
                    end
                end
                if (full_wr && hit_prog && busy)
                    wr_conflict <= 1'b1;
            end

            if (frame_start && busy)
                overrun <= 1'b1;

            case (state_q)
                IDLE: if (frame_start && enable) pc <= '0;
                FETCH: ir <= prog[pc];
                EXEC: begin
                    case (opcode)
                        OP_NOOP, OP_HALT: ;
                        OP_MAC:  acc <= acc + prod_ext;
                        OP_MACZ: acc <= prod_ext;
                        OP_MSU:  acc <= acc - prod_ext;
                        OP_SAVE: begin
                            out_valid <= 1'b1;
                            out_chan  <= ir[16 +: CHAN_W];
                            out_data  <= sat_val;
                        end
                        default: bad_op <= 1'b1;
                    endcase
                    if (!run_end)
                        pc <= pc + PC_W'(1);
                end
                default: ;
            endcase
        end
    end
endmodule
